// File: rtl/evict_pkg.sv
// Shared types and helpers for the tree-PLRU eviction engine.
package evict_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    READY  = 2'd2
  } evict_state_e;

  // log2 of a power-of-two way count
  function automatic int levels_of(input int n);
    int l;
    l = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) l = i + 1;
    end
    return l;
  endfunction

endpackage

// File: rtl/plru_path_update.sv
// Combinational tree-PLRU touch: points every node on the accessed way's
// root-to-leaf path away from it. Non-one-hot way leaves the tree unchanged.
module plru_path_update
  import evict_pkg::*;
#(
  parameter int NUM_WAYS = 512
) (
  input  logic [NUM_WAYS-1:0] tree,
  input  logic [NUM_WAYS-1:0] way,
  output logic [NUM_WAYS-1:0] tree_next
);

  localparam int LEVELS = levels_of(NUM_WAYS);

  logic              one_hot;
  logic [LEVELS-1:0] idx;
  logic [LEVELS-1:0] node;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (way[i]) idx = idx | LEVELS'(i);
    end
    one_hot   = (way != '0) && ((way & (way - NUM_WAYS'(1))) == '0);
    tree_next = tree;
    node      = '0;
    if (one_hot) begin
      // ancestor at depth l is (leaf heap index) >> (LEVELS - l)
      for (int l = 0; l < LEVELS; l++) begin
        node            = LEVELS'((NUM_WAYS + int'(idx)) >> (LEVELS - l));
        tree_next[node] = ~idx[LEVELS-1-l];
      end
    end
  end

endmodule

// File: rtl/plru_eviction_engine.sv
// Tree-PLRU victim selector with a snapshot-walking search FSM.
// Optional macro EVICT_INVALID_FIRST_EN: prefer the lowest-index invalid way.
module plru_eviction_engine
  import evict_pkg::*;
#(
  parameter int NUM_WAYS      = 512,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_WAYS-1:0] hitWay,
  input  logic                hit,
  input  logic [NUM_WAYS-1:0] missWay,
  input  logic                miss,
  input  logic [NUM_WAYS-1:0] allocateWay,
  input  logic                allocate,
  output logic [NUM_WAYS-1:0] evictionTarget,
  output logic                evictionReady
);

  localparam int LEVELS = levels_of(NUM_WAYS);

  evict_state_e        state;
  logic [NUM_WAYS-1:0] tree;
  logic [NUM_WAYS-1:0] snap;
  logic [NUM_WAYS-1:0] tree_hit;
  logic [NUM_WAYS-1:0] tree_alloc;
  logic [LEVELS-1:0]   lvl;
  logic [LEVELS-1:0]   node;
  logic [LEVELS:0]     leaf;
  logic                unused_inputs;

  assign unused_inputs = ^{missWay, ADDRESS_WIDTH == 0};

  // Hit is applied first, allocate second so it wins on shared nodes
  plru_path_update #(.NUM_WAYS(NUM_WAYS)) u_hit_update (
    .tree      (tree),
    .way       (hitWay & {NUM_WAYS{hit}}),
    .tree_next (tree_hit)
  );

  plru_path_update #(.NUM_WAYS(NUM_WAYS)) u_alloc_update (
    .tree      (tree_hit),
    .way       (allocateWay & {NUM_WAYS{allocate}}),
    .tree_next (tree_alloc)
  );

  assign leaf = {node, snap[node]};

`ifdef EVICT_INVALID_FIRST_EN
  logic [NUM_WAYS-1:0] valid;
  logic [NUM_WAYS-1:0] inv_target;
  logic                pend_inv;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      tree           <= '0;
      lvl            <= '0;
      node           <= LEVELS'(1);
      evictionReady  <= 1'b0;
      evictionTarget <= '0;
`ifdef EVICT_INVALID_FIRST_EN
      valid          <= '0;
      pend_inv       <= 1'b0;
`endif
    end else begin
      tree <= tree_alloc;
`ifdef EVICT_INVALID_FIRST_EN
      valid <= valid | (allocate ? allocateWay : '0);
`endif
      case (state)
        IDLE: begin
`ifdef EVICT_INVALID_FIRST_EN
          // one hold cycle in IDLE stands in for the PLRU walk
          if (pend_inv) begin
            pend_inv       <= 1'b0;
            evictionTarget <= inv_target;
            evictionReady  <= 1'b1;
            state          <= READY;
          end else if (miss && !(&valid)) begin
            pend_inv   <= 1'b1;
            inv_target <= ~valid & (valid + NUM_WAYS'(1));
          end else
`endif
          if (miss) begin
            snap  <= tree;
            lvl   <= '0;
            node  <= LEVELS'(1);
            state <= SEARCH;
          end
        end
        SEARCH: begin
          node <= leaf[LEVELS-1:0];
          lvl  <= lvl + LEVELS'(1);
          if (lvl == LEVELS'(LEVELS - 1)) begin
            evictionTarget <= NUM_WAYS'(1) << leaf[LEVELS-1:0];
            evictionReady  <= 1'b1;
            state          <= READY;
          end
        end
        READY: begin
          if (allocate) begin
            evictionTarget <= '0;
            evictionReady  <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plru_eviction_engine.sv
// Self-checking bench for plru_eviction_engine (NUM_WAYS=8): directed cases plus randomized traffic against a tree model.
module tb_plru_eviction_engine;

  localparam int NW = 8;
  localparam int LV = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NW-1:0] hitWay, missWay, allocateWay;
  logic          hit, miss, allocate;
  logic [NW-1:0] evictionTarget;
  logic          evictionReady;

  int checks = 0;
  int errors = 0;

  plru_eviction_engine #(.NUM_WAYS(NW), .ADDRESS_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .hitWay         (hitWay),
    .hit            (hit),
    .missWay        (missWay),
    .miss           (miss),
    .allocateWay    (allocateWay),
    .allocate       (allocate),
    .evictionTarget (evictionTarget),
    .evictionReady  (evictionReady)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit            m_tree [NW];
  bit [NW-1:0]   m_valid;
  int            m_st;      // 0 idle, 1 busy, 2 ready
  int            m_cd;
  int            m_vict;
  bit            exp_rdy;
  bit [NW-1:0]   exp_tgt;
  bit            armed = 0;

  function automatic int m_victim();
    int n;
    n = 1;
    for (int l = 0; l < LV; l++) n = 2 * n + int'(m_tree[n]);
    return n - NW;
  endfunction

  task automatic m_access(input logic [NW-1:0] oh);
    int w, p;
    if ($countones(oh) != 1) return;
    w = 0;
    for (int i = 0; i < NW; i++) if (oh[i]) w = i;
    p = NW + w;
    while (p > 1) begin
      m_tree[p / 2] = (p % 2 == 0);   // came from lower child -> point upper
      p = p / 2;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NW; i++) m_tree[i] = 0;
      m_valid = '0; m_st = 0; m_cd = 0;
      exp_rdy = 0; exp_tgt = '0; armed = 1;
    end else if (armed) begin
      case (m_st)
        0: if (miss) begin
`ifdef EVICT_INVALID_FIRST_EN
          if (m_valid != '1) begin
            m_vict = 0;
            for (int i = NW - 1; i >= 0; i--) if (!m_valid[i]) m_vict = i;
            m_cd = 1;
          end else begin
            m_vict = m_victim(); m_cd = LV;
          end
`else
          m_vict = m_victim(); m_cd = LV;
`endif
          m_st = 1;
        end
        1: begin
          m_cd--;
          if (m_cd == 0) begin
            m_st = 2; exp_rdy = 1; exp_tgt = NW'(1) << m_vict;
          end
        end
        default: if (allocate) begin
          m_st = 0; exp_rdy = 0; exp_tgt = '0;
        end
      endcase
      if (hit) m_access(hitWay);
      if (allocate) begin
        m_access(allocateWay);
        m_valid = m_valid | allocateWay;
      end
    end
  end

  always @(negedge clk) begin
    if (armed && !reset) begin
      checks++;
      if (evictionReady !== exp_rdy || evictionTarget !== exp_tgt) begin
        errors++;
        $display("FAIL model_cmp t=%0t actual rdy=%0b tgt=%02h required rdy=%0b tgt=%02h",
                 $time, evictionReady, evictionTarget, exp_rdy, exp_tgt);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("reset_rdy", {31'd0, evictionReady}, 32'd0);
    chk("reset_tgt", {24'd0, evictionTarget}, 32'd0);
  endtask

  task automatic do_miss(input string name, input logic [NW-1:0] tgt, input int lat_req,
                         input logic [NW-1:0] hit_c1);
    int lat;
    @(negedge clk); miss = 1'b1;
    @(negedge clk); miss = 1'b0;
    if (hit_c1 != '0) begin hit = 1'b1; hitWay = hit_c1; end
    lat = 1;
    while (!evictionReady && lat < 20) begin
      @(negedge clk);
      hit = 1'b0; hitWay = '0;
      lat++;
    end
    hit = 1'b0; hitWay = '0;
    chk({name, "_lat"}, lat, lat_req);
    chk({name, "_tgt"}, {24'd0, evictionTarget}, {24'd0, tgt});
  endtask

  task automatic do_alloc(input logic [NW-1:0] w);
    @(negedge clk); allocate = 1'b1; allocateWay = w;
    @(negedge clk); allocate = 1'b0; allocateWay = '0;
    chk("alloc_rdy_drop", {31'd0, evictionReady}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; hit = 0; miss = 0; allocate = 0;
    hitWay = '0; missWay = '0; allocateWay = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_reset();
`ifndef EVICT_INVALID_FIRST_EN
    do_miss("first_miss", 8'h01, 4, '0);
    do_alloc(8'h01);
    do_miss("after_a01", 8'h10, 4, '0);
    do_alloc(8'h10);
    do_miss("after_a10", 8'h04, 4, '0);
    do_alloc(8'h04);
    do_reset();
    do_miss("hit_in_search", 8'h01, 4, 8'h01);
    do_alloc(8'h01);
    do_miss("hit_then_alloc", 8'h10, 4, '0);
    do_reset();
    do_miss("pre_ready_reset", 8'h01, 4, '0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("ready_reset_rdy", {31'd0, evictionReady}, 32'd0);
    chk("ready_reset_tgt", {24'd0, evictionTarget}, 32'd0);
    do_miss("post_reset_miss", 8'h01, 4, '0);
    do_reset();
    @(negedge clk); hit = 1'b1; hitWay = 8'h03;
    @(negedge clk); hit = 1'b0; hitWay = '0;
    do_miss("multi_hot_hit", 8'h01, 4, '0);
    @(negedge clk); miss = 1'b1;
    @(negedge clk); miss = 1'b0;
    repeat (4) @(negedge clk);
    chk("miss_in_ready_tgt", {24'd0, evictionTarget}, 32'h01);
    chk("miss_in_ready_rdy", {31'd0, evictionReady}, 32'd1);
    do_alloc(8'h01);
`else
    do_alloc(8'h01); do_alloc(8'h02); do_alloc(8'h04);
    do_miss("invalid_first", 8'h08, 2, '0);
    do_alloc(8'h08);
`endif
    // randomized traffic checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 199) == 0);
      miss     = ($urandom_range(0, 3) == 0);
      hit      = ($urandom_range(0, 2) == 0);
      hitWay   = ($urandom_range(0, 3) != 0) ? NW'(1) << $urandom_range(0, NW - 1) : NW'($urandom);
      allocate = ($urandom_range(0, 5) == 0);
      allocateWay = ($urandom_range(0, 5) != 0) ? NW'(1) << $urandom_range(0, NW - 1) : NW'($urandom);
      missWay  = NW'($urandom);
    end
    @(negedge clk);
    reset = 0; hit = 0; miss = 0; allocate = 0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
